// File: rtl/divider_stg_pkg.sv
// Shared definitions for the sequential signed divider: default width, controller states, counter sizing.
package divider_stg_pkg;

    localparam int unsigned L_WORD_DEF = 4;

    typedef enum logic [1:0] {
        S_idle = 2'd0,
        S_run  = 2'd1,
        S_fix  = 2'd2,
        S_done = 2'd3
    } state_t;

    // Iteration counter must hold values 0..L_word.
    function automatic int unsigned cnt_width(input int unsigned l_word);
        return $clog2(l_word + 1);
    endfunction

endpackage

// File: rtl/divider_datapath_stg.sv
// Divider datapath: operand magnitudes, restoring-division shift/subtract, sign correction and flags.
module divider_datapath_stg
    import divider_stg_pkg::*;
#(
    parameter int unsigned L_word = L_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [L_word-1:0] word1,
    input  logic [L_word-1:0] word2,
    input  logic              load,
    input  logic              skip,
    input  logic              shift,
    input  logic              sub,
    input  logic              fix,
    output logic              ge_c,
    output logic              zero_c,
    output logic [L_word-1:0] quotient,
    output logic [L_word-1:0] remainder,
    output logic              overflow
);

    localparam int unsigned LW = L_word;
    localparam int unsigned LX = L_word + 1;

    logic [LX-1:0] mag1;
    logic [LX-1:0] mag2;
    logic [LX-1:0] dvsr;
    logic [LX-1:0] partial;
    logic [LW-1:0] acc;
    logic [LW-1:0] rem;
    logic          neg_a;
    logic          neg_b;
    logic [LW-1:0] q_fix;
    logic [LW-1:0] r_fix;
    logic          ovf_fix;

    // Magnitudes are formed one bit wider so the most negative operand survives.
    always_comb begin
        mag1 = {word1[LW-1], word1};
        mag2 = {word2[LW-1], word2};
        if (word1[LW-1]) mag1 = LX'(0) - mag1;
        if (word2[LW-1]) mag2 = LX'(0) - mag2;

        partial = {rem, acc[LW-1]};
        ge_c    = (partial >= dvsr);
        zero_c  = (dvsr == '0);

        q_fix   = (neg_a ^ neg_b) ? LW'(0) - acc : acc;
        if (zero_c) q_fix = '1;
        r_fix   = neg_a ? LW'(0) - rem : rem;
        // Only |most negative| / 1 yields a quotient magnitude with the top bit set.
        ovf_fix = neg_a & neg_b & (dvsr == LX'(1)) & acc[LW-1];
    end

    // acc holds the dividend magnitude and collects quotient bits from the right.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (load) begin
            acc       <= skip ? '0 : LW'(mag1);
            rem       <= skip ? LW'(mag1) : '0;
            dvsr      <= mag2;
            neg_a     <= word1[LW-1];
            neg_b     <= word2[LW-1];
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
        end else if (shift) begin
            rem <= sub ? LW'(partial - dvsr) : LW'(partial);
            acc <= {acc[LW-2:0], sub};
        end else if (fix) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            overflow  <= ovf_fix;
        end
    end

endmodule

// File: rtl/divider_signed_stg.sv
// Sequential signed divider top: Start/Ready controller around the datapath.
// Optional DIVIDER_EARLY_EXIT_EN skips the iterations for zero divisors and |word1| < |word2|.
module divider_signed_stg
    import divider_stg_pkg::*;
#(
    parameter int unsigned L_word = L_WORD_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [L_word-1:0] word1,
    input  logic [L_word-1:0] word2,
    input  logic              Start,
    output logic [L_word-1:0] quotient,
    output logic [L_word-1:0] remainder,
    output logic              Ready,
    output logic              div_zero,
    output logic              overflow
);

    localparam int unsigned CW = cnt_width(L_word);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          load;
    logic          skip;
    logic          shift;
    logic          sub;
    logic          fix;
    logic          ge_c;
    logic          zero_c;

`ifdef DIVIDER_EARLY_EXIT_EN
    localparam int unsigned LX = L_word + 1;
    logic [LX-1:0] m1;
    logic [LX-1:0] m2;

    // Load-time check: result is already known without iterating.
    always_comb begin
        m1 = {word1[L_word-1], word1};
        m2 = {word2[L_word-1], word2};
        if (word1[L_word-1]) m1 = LX'(0) - m1;
        if (word2[L_word-1]) m2 = LX'(0) - m2;
        skip = (word2 == '0) || (m1 < m2);
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_idle;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        shift   = 1'b0;
        sub     = 1'b0;
        fix     = 1'b0;
        case (state)
            S_idle, S_done: begin
                if (Start) begin
                    load    = 1'b1;
                    state_n = skip ? S_fix : S_run;
                end
            end
            S_run: begin
                shift = 1'b1;
                sub   = ge_c;
                if (cnt == CW'(L_word - 1)) state_n = S_fix;
            end
            S_fix: begin
                fix     = 1'b1;
                state_n = S_done;
            end
            default: state_n = S_idle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            div_zero <= 1'b0;
        end else begin
            if (load)       cnt <= '0;
            else if (shift) cnt <= cnt + CW'(1);
            if (load)       div_zero <= 1'b0;
            else if (fix)   div_zero <= zero_c;
        end
    end

    assign Ready = ((state == S_idle) && reset) || (state == S_done);

    divider_datapath_stg #(
        .L_word(L_word)
    ) u_dp (
        .clock    (clock),
        .reset    (reset),
        .word1    (word1),
        .word2    (word2),
        .load     (load),
        .skip     (skip),
        .shift    (shift),
        .sub      (sub),
        .fix      (fix),
        .ge_c     (ge_c),
        .zero_c   (zero_c),
        .quotient (quotient),
        .remainder(remainder),
        .overflow (overflow)
    );

endmodule
